// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the serial subtractor.
// Imported by the top and the digit slice.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit-counter width: clog2(width/digit), never below one bit.
  function automatic int cnt_width(
    input int width,
    input int digit
  );
    int n;
    n = width / digit;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit ripple-borrow slice.
// Borrow enters at bit 0 and leaves from the top bit.
module sub_digit
  import serial_subtractor_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             br_in,
  output logic [DIGIT-1:0] d,
  output logic             br_out
);

  // Ripple the borrow through each bit, LSB first.
  always_comb begin : ripple
    logic br;
    d  = '0;
    br = br_in;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a_d[i] ^ b_d[i] ^ br;
      br   = (~a_d[i] & b_d[i])
           | (~(a_d[i] ^ b_d[i]) & br);
    end
    br_out = br;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock, LSB first.
// Result and borrow-out load only on the RUN->DONE edge.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(WIDTH, DIGIT);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad
      $error("serial_subtractor: DIGIT must divide WIDTH");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [DIGIT-1:0]       dig;
  logic                   br_nx;
  logic [WIDTH+DIGIT-1:0] work_cat;
  logic [WIDTH-1:0]       work_sh;

  sub_digit #(
    .DIGIT(DIGIT)
  ) u_slice (
    .a_d   (a_sh_q[DIGIT-1:0]),
    .b_d   (b_sh_q[DIGIT-1:0]),
    .br_in (br_q),
    .d     (dig),
    .br_out(br_nx)
  );

  assign work_cat = {dig, work_q};
  assign work_sh  = work_cat[WIDTH+DIGIT-1:DIGIT];

  // Next-state, datapath steering and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    br_d    = br_q;
    work_d  = work_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          work_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        br_d   = br_nx;
        work_d = work_sh;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          diff_d  = work_sh;
          bout_d  = br_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      br_q    <= 1'b0;
      work_q  <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      br_q    <= br_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule
